// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer:
//   - opcode encodings driven to the downstream fixed-point ALU
//   - default operand width (DEF_N) and fractional bit count (DEF_Q)
//   - sequencer FSM state encoding
//   - overflow helper used when ALU_SEQ_OVF_FLAG_EN is defined
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    localparam int DEF_N = 32;
    localparam int DEF_Q = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_HOLD  = 2'b10
    } seq_state_t;

    // Signed two's-complement overflow from the sign bits of the operands and
    // the result. Subtraction overflows when the operand signs differ and the
    // result sign no longer matches the minuend.
    function automatic logic ovf_flag(input logic [1:0] op,
                                      input logic       sign_a,
                                      input logic       sign_b,
                                      input logic       sign_r);
        logic flag;
        flag = 1'b0;
        case (op)
            OP_ADD:          flag = (sign_a == sign_b) && (sign_r != sign_a);
            OP_SUB:          flag = (sign_a != sign_b) && (sign_r != sign_a);
            OP_MULT, OP_DIV: flag = 1'b0;
            default:         flag = 1'b0;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO with a synchronous flush. The head entry is shown
// combinationally on pop_data; a pop only ever removes an entry that was
// already stored before the edge, so a push into an empty FIFO is poppable
// from the following cycle.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous clear; wins over push and pop
//   push/push_data write request and entry (ignored when full)
//   pop            read request (ignored when empty)
//   pop_data       head entry
//   full, empty    occupancy flags
// ----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; validity is tracked by count, so clearing
    // the array would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide on a power-of-two depth, so they wrap modulo
    // DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff sees the pre-edge values, independent of block ordering.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Queues {op, a, b} commands and feeds them one at a time to an external
// combinational fixed-point ALU. Each command is registered onto alu_a /
// alu_b / alu_op, the ALU is given one full cycle, and its result is captured
// into out_data / out_op and held under a valid/ready handshake.
//
// Parameters: N (operand width), Q (fractional bits, informational),
//             DEPTH (command FIFO depth, power of two, >= 2)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous clear of queue, issue and result
//   in_valid/in_ready           command handshake (in_ready = FIFO not full)
//   in_op, in_a, in_b           command opcode and operands
//   alu_a, alu_b, alu_op        registered operands/opcode to the ALU
//   alu_out                     combinational ALU result
//   out_valid/out_ready         result handshake
//   out_data, out_op            captured result and its opcode
//   out_ovf                     add/sub overflow flag (ALU_SEQ_OVF_FLAG_EN only)
//   busy                        queue non-empty or FSM not idle
//
// Build option: define ALU_SEQ_OVF_FLAG_EN to add the out_ovf output.
// ----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int Q     = DEF_Q,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_op,
`ifdef ALU_SEQ_OVF_FLAG_EN
    output logic         out_ovf,
`endif
    output logic         busy
);

    localparam int CW = 2 + 2 * N;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_op_sequencer: DEPTH must be a power of two and at least 2");
    end
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("alu_op_sequencer: Q must lie in 0..N-1");
    end

    seq_state_t     state;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop_req;
    logic [CW-1:0]  fifo_head;
    logic [1:0]     head_op;
    logic [N-1:0]   head_a;
    logic [N-1:0]   head_b;

    alu_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (in_valid),
        .push_data ({in_op, in_a, in_b}),
        .pop       (pop_req),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_op  = fifo_head[CW-1 -: 2];
    assign head_a   = fifo_head[2*N-1 -: N];
    assign head_b   = fifo_head[N-1:0];

    // in_ready depends only on registered occupancy, so a full FIFO stays
    // closed even in a cycle where it is also being popped.
    assign in_ready = !fifo_full;
    assign busy     = !fifo_empty || (state != S_IDLE);

    // Pop whenever the FSM is about to load the ALU registers: from IDLE, or
    // from HOLD on the edge the current result is consumed.
    always_comb begin
        // NOTE: default first so every path assigns pop_req; otherwise a latch is inferred.
        pop_req = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE) begin
                pop_req = 1'b1;
            end else if (state == S_HOLD && out_ready) begin
                pop_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
`ifdef ALU_SEQ_OVF_FLAG_EN
            out_ovf   <= 1'b0;
`endif
        end else if (flush) begin
            // The last captured out_data/out_op are left as they are; only
            // out_valid says whether they mean anything.
            state     <= S_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a  <= head_a;
                        alu_b  <= head_b;
                        alu_op <= head_op;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // alu_a/alu_b/alu_op have been stable for a full cycle.
                    out_data  <= alu_out;
                    out_op    <= alu_op;
`ifdef ALU_SEQ_OVF_FLAG_EN
                    out_ovf   <= ovf_flag(alu_op, alu_a[N-1], alu_b[N-1], alu_out[N-1]);
`endif
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!fifo_empty) begin
                            alu_a  <= head_a;
                            alu_b  <= head_b;
                            alu_op <= head_op;
                            state  <= S_ISSUE;
                        end else begin
                            state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. The bench supplies the fixed-point ALU
// itself and keeps a queue of accepted commands; a monitor compares every
// consumed result against that queue, checks busy every cycle and checks
// that held results stay stable. Directed steps pin latency, back-pressure,
// flush and asynchronous reset with literal values.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int N     = 32;
    localparam int Q     = 20;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_out;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   out_op;
    logic         busy;
`ifdef ALU_SEQ_OVF_FLAG_EN
    logic         out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    cmd_t exp_q[$];

    alu_op_sequencer #(
        .N     (N),
        .Q     (Q),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
`ifdef ALU_SEQ_OVF_FLAG_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    // Fixed-point ALU, Q-format signed arithmetic in 64-bit integers.
    function automatic logic [N-1:0] alu_fn(input logic [1:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            2'b10:   r = (sa * sb) >>> Q;
            default: r = (sb == 0) ? 64'sd0 : (sa <<< Q) / sb;
        endcase
        return r[N-1:0];
    endfunction

    // Overflow means the exact add/sub result does not fit in N signed bits.
    function automatic logic exp_ovf(input logic [1:0] op,
                                     input logic [N-1:0] a,
                                     input logic [N-1:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'b00)      r = sa + sb;
        else if (op == 2'b01) r = sa - sb;
        else                  return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         prev_hold = 1'b0;
    logic [N-1:0] prev_data = '0;
    logic [1:0]   prev_op   = '0;
    cmd_t         head;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_op", 64'(out_op), 64'(prev_op));
            end
            check("busy", 64'(busy), 64'(exp_q.size() != 0));
            if (out_valid) begin
                check("valid_has_cmd", 64'(exp_q.size() != 0), 64'(1));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    check("result_data", 64'(out_data), 64'(alu_fn(head.op, head.a, head.b)));
                    check("result_op", 64'(out_op), 64'(head.op));
`ifdef ALU_SEQ_OVF_FLAG_EN
                    check("result_ovf", 64'(out_ovf), 64'(exp_ovf(head.op, head.a, head.b)));
`endif
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({in_op, in_a, in_b});
                end
            end
            prev_hold <= out_valid && !out_ready && !flush;
            prev_data <= out_data;
            prev_op   <= out_op;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("push_accepted", 64'(in_ready), 64'(1));
        sync();
        in_valid = 1'b0;
    endtask

    // Returns on the falling edge where out_valid is seen; cycles counts the
    // falling edges observed, including that one.
    task automatic wait_result(input string name, input logic [N-1:0] d,
                               input logic [1:0] op, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 50);
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_data"}, 64'(out_data), 64'(d));
        check({name, "_op"}, 64'(out_op), 64'(op));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || out_valid) && n < 100);
        check("wait_idle", 64'(busy | out_valid), 64'(0));
        sync();
    endtask

    // ---------------- directed sequence ----------------
    logic [N-1:0] bp_a   [5] = '{32'h00100000, 32'h00200000, 32'h00300000, 32'h00400000, 32'h00500000};
    logic [N-1:0] bp_res [5] = '{32'h00110000, 32'h00210000, 32'h00310000, 32'h00410000, 32'h00510000};

    initial begin
        int cyc;
        logic saw;

        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        check("rst_alu_b", 64'(alu_b), 64'(0));
        check("rst_alu_op", 64'(alu_op), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_op", 64'(out_op), 64'(0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        sync();

        // Add, latency of two edges from acceptance.
        out_ready = 1'b1;
        push_cmd(2'b00, 32'h00180000, 32'h00200000);
        @(negedge clk);
        check("lat_e0_valid", 64'(out_valid), 64'(0));
        check("lat_e0_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("lat_e1_valid", 64'(out_valid), 64'(0));
        check("lat_e1_alu_a", 64'(alu_a), 64'h00180000);
        check("lat_e1_alu_b", 64'(alu_b), 64'h00200000);
        check("lat_e1_alu_op", 64'(alu_op), 64'(2'b00));
        @(negedge clk);
        check("lat_e2_valid", 64'(out_valid), 64'(1));
        check("add_data", 64'(out_data), 64'h00380000);
        check("add_op", 64'(out_op), 64'(2'b00));
        wait_idle();

        // Sub, mult, div.
        push_cmd(2'b01, 32'h00180000, 32'h00200000);
        wait_result("sub", 32'hFFF80000, 2'b01, cyc);
        check("sub_latency", 64'(cyc), 64'(3));
        wait_idle();
        push_cmd(2'b10, 32'h00180000, 32'h00200000);
        wait_result("mult", 32'h00300000, 2'b10, cyc);
        wait_idle();
        push_cmd(2'b11, 32'h00300000, 32'h00200000);
        wait_result("div", 32'h00180000, 2'b11, cyc);
        wait_idle();

        // Back-pressure: 4 queued plus 1 issued fills the block.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(2'b00, bp_a[i], 32'h00010000);
        end
        @(negedge clk);
        check("bp_full_ready", 64'(in_ready), 64'(0));
        check("bp_first_valid", 64'(out_valid), 64'(1));
        check("bp_first_data", 64'(out_data), 64'(bp_res[0]));
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", 64'(in_ready), 64'(0));
            check("bp_stall_data", 64'(out_data), 64'(bp_res[0]));
        end
        sync();
        out_ready = 1'b1;
        wait_result("bp0", bp_res[0], 2'b00, cyc);
        check("full_pop_ready", 64'(in_ready), 64'(0));
        for (int i = 1; i < 5; i++) begin
            wait_result("bp_drain", bp_res[i], 2'b00, cyc);
            check("bp_throughput", 64'(cyc), 64'(2));
        end
        wait_idle();

        // Flush while holding a result with three commands queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'b00, bp_a[i], 32'h00010000);
        end
        @(negedge clk);
        check("fl_pre_valid", 64'(out_valid), 64'(1));
        sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
        @(negedge clk);
        check("fl_valid", 64'(out_valid), 64'(0));
        check("fl_busy", 64'(busy), 64'(0));
        check("fl_in_ready", 64'(in_ready), 64'(1));
        check("fl_alu_a", 64'(alu_a), 64'(0));
        check("fl_alu_op", 64'(alu_op), 64'(0));
        sync();
        out_ready = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("fl_no_result", 64'(saw), 64'(0));
        sync();

        // Asynchronous reset while the command sits in ISSUE.
        push_cmd(2'b01, 32'h00300000, 32'h00100000);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_alu_op", 64'(alu_op), 64'(2'b01));
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_alu_a", 64'(alu_a), 64'(0));
        check("arst_alu_b", 64'(alu_b), 64'(0));
        check("arst_alu_op", 64'(alu_op), 64'(0));
        check("arst_out_data", 64'(out_data), 64'(0));
        check("arst_out_op", 64'(out_op), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("arst_no_result", 64'(saw), 64'(0));
        sync();
        push_cmd(2'b00, 32'h00180000, 32'h00200000);
        wait_result("post_rst", 32'h00380000, 2'b00, cyc);
        wait_idle();

`ifdef ALU_SEQ_OVF_FLAG_EN
        push_cmd(2'b00, 32'h7FFFFFFF, 32'h00000001);
        wait_result("ovf_add", 32'h80000000, 2'b00, cyc);
        check("ovf_add_flag", 64'(out_ovf), 64'(1));
        wait_idle();
        push_cmd(2'b10, 32'h7FFFFFFF, 32'h00000001);
        wait_result("ovf_mult", 32'h000007FF, 2'b10, cyc);
        check("ovf_mult_flag", 64'(out_ovf), 64'(0));
        wait_idle();
        push_cmd(2'b01, 32'h80000000, 32'h00000001);
        wait_result("ovf_sub", 32'h7FFFFFFF, 2'b01, cyc);
        check("ovf_sub_flag", 64'(out_ovf), 64'(1));
        wait_idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
